// File: rtl/fifo_wptr_full_if.sv
// -----------------------------------------------------------------------------
// fifo_wptr_full_if
// Purpose : bundles the write-side handshake and status signals of the
//           dual-clock FIFO write-pointer controller.
// Signals :
//   winc         producer -> ctrl   write request
//   wover_clr    producer -> ctrl   clear sticky overflow
//   wq2_rptr     sync     -> ctrl   Gray read pointer, already in wclk domain
//   wclken       ctrl -> memory     write enable
//   waddr        ctrl -> memory     write address
//   wptr         ctrl -> sync       registered Gray write pointer
//   wfull        ctrl -> producer   registered full flag
//   wlevel       ctrl -> producer   registered occupancy (0..DEPTH)
//   wover        ctrl -> producer   sticky overflow flag
//   walmost_full ctrl -> producer   registered almost-full flag
// Modports: master = producer/environment side, slave = controller side.
// -----------------------------------------------------------------------------
interface fifo_wptr_full_if #(
    parameter int ADDRSIZE = 4
);
    logic                winc;
    logic                wover_clr;
    logic [ADDRSIZE:0]   wq2_rptr;
    logic                wclken;
    logic [ADDRSIZE-1:0] waddr;
    logic [ADDRSIZE:0]   wptr;
    logic                wfull;
    logic [ADDRSIZE:0]   wlevel;
    logic                wover;
    logic                walmost_full;

    modport master (
        output winc, wover_clr, wq2_rptr,
        input  wclken, waddr, wptr, wfull, wlevel, wover, walmost_full
    );

    modport slave (
        input  winc, wover_clr, wq2_rptr,
        output wclken, waddr, wptr, wfull, wlevel, wover, walmost_full
    );
endinterface

// File: rtl/fifo_wptr_full.sv
// -----------------------------------------------------------------------------
// fifo_wptr_full
// Purpose : write-side pointer and full-flag controller of the dual-clock FIFO.
//           Holds the binary and Gray write pointers, drives the memory write
//           address/enable, and compares the next pointer with the
//           synchronised read pointer to produce full, level and overflow.
// Ports   :
//   wclk    in   write-domain clock
//   wrst_n  in   synchronous active-low reset, sampled on posedge wclk
//   w       fifo_wptr_full_if.slave (see interface header for members)
// Option  : FIFO_ALMOST_FULL_EN - when defined, builds the registered
//           walmost_full comparator (level >= AFULL_THRESH); otherwise
//           walmost_full is tied to 0.
// -----------------------------------------------------------------------------
module fifo_wptr_full #(
    parameter int DATASIZE     = 8,
    parameter int ADDRSIZE     = 4,
    parameter int AFULL_THRESH = 12
) (
    input  logic                  wclk,
    input  logic                  wrst_n,
    fifo_wptr_full_if.slave       w
);
    localparam int A     = ADDRSIZE;
    localparam int DEPTH = 1 << ADDRSIZE;

    // Parameter sanity; DATASIZE only exists to keep the FIFO parameter set uniform.
    if (ADDRSIZE < 2) begin : g_bad_addrsize
        $error("fifo_wptr_full: ADDRSIZE must be >= 2");
    end
    if (DATASIZE < 1) begin : g_bad_datasize
        $error("fifo_wptr_full: DATASIZE must be >= 1");
    end
    if (AFULL_THRESH < 1 || AFULL_THRESH > DEPTH) begin : g_bad_thresh
        $error("fifo_wptr_full: AFULL_THRESH out of range 1..DEPTH");
    end

    logic [A:0] wbin;
    logic [A:0] wptr_q;
    logic       wfull_q;
    logic [A:0] wlevel_q;
    logic       wover_q;

    logic       wclken;
    logic [A:0] wbinnext;
    logic [A:0] wgraynext;
    logic [A:0] rbin;
    logic [A:0] full_cmp;
    logic [A:0] levelnext;

    // Reset gates the enable so the memory is never written during reset.
    assign wclken    = w.winc & ~wfull_q & wrst_n;
    assign wbinnext  = wbin + {{A{1'b0}}, wclken};
    assign wgraynext = (wbinnext >> 1) ^ wbinnext;

    // Full when the next write pointer equals the read pointer with the top
    // two Gray bits inverted (same index, one lap ahead).
    assign full_cmp  = {~w.wq2_rptr[A:A-1], w.wq2_rptr[A-2:0]};

    // Gray to binary: each bit is the XOR of itself and all bits above it.
    always_comb begin
        rbin = '0;
        for (int i = 0; i <= A; i++) begin
            rbin[i] = ^(w.wq2_rptr >> i);
        end
    end

    assign levelnext = wbinnext - rbin;

    always_ff @(posedge wclk) begin
        if (!wrst_n) begin
            wbin     <= '0;
            wptr_q   <= '0;
            wfull_q  <= 1'b0;
            wlevel_q <= '0;
            wover_q  <= 1'b0;
        end else begin
            wbin     <= wbinnext;
            wptr_q   <= wgraynext;
            wfull_q  <= (wgraynext == full_cmp);
            wlevel_q <= levelnext;
            // A fresh overflow takes priority over a simultaneous clear.
            if (w.winc && wfull_q) begin
                wover_q <= 1'b1;
            end else if (w.wover_clr) begin
                wover_q <= 1'b0;
            end
        end
    end

`ifdef FIFO_ALMOST_FULL_EN
    localparam logic [A:0] AFULL_V = (A+1)'(AFULL_THRESH);
    logic walmost_full_q;

    always_ff @(posedge wclk) begin
        if (!wrst_n) begin
            walmost_full_q <= 1'b0;
        end else begin
            walmost_full_q <= (levelnext >= AFULL_V);
        end
    end

    assign w.walmost_full = walmost_full_q;
`else
    assign w.walmost_full = 1'b0;
`endif

    assign w.wclken = wclken;
    assign w.waddr  = wbin[A-1:0];
    assign w.wptr   = wptr_q;
    assign w.wfull  = wfull_q;
    assign w.wlevel = wlevel_q;
    assign w.wover  = wover_q;
endmodule
